// File: rtl/ioctl_ram_upload_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ioctl_ram_upload_pkg
// Description : Shared types and constants for the HPS ioctl upload responder.
//               Holds the FSM state encoding, the default fill byte and the
//               pending-request record used by the 1-deep request slot.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ioctl_ram_upload_pkg;

  // Width of the ioctl byte address delivered by hps_io.
  localparam int IOCTL_AW = 25;

  // Byte returned for reads that fall outside the game RAM window.
  localparam logic [7:0] UPL_FILL_DEFAULT = 8'hFF;

  // Upload FSM states.
  typedef enum logic [2:0] {
    UPL_IDLE    = 3'd0,
    UPL_PAUSE   = 3'd1,
    UPL_READY   = 3'd2,
    UPL_FETCH   = 3'd3,
    UPL_RELEASE = 3'd4
  } upl_state_t;

  // One outstanding ioctl read that could not be served yet.
  typedef struct packed {
    logic                valid;
    logic [IOCTL_AW-1:0] addr;
  } upl_pend_t;

  // True when an ioctl address falls inside a 2^aw byte window.
  function automatic logic upl_in_window(input logic [IOCTL_AW-1:0] addr,
                                         input int unsigned         aw);
    if (aw >= IOCTL_AW) begin
      return 1'b1;
    end
    return ((addr >> aw) == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ioctl_ram_upload_if.sv
`default_nettype none
// ============================================================================
// Module      : ioctl_ram_upload_if
// Description : Bundle of the ioctl upload channel, the CPU pause handshake,
//               the game RAM read port and the status outputs.
// Ports       : (interface signals)
//   ioctl_upload, ioctl_rd, ioctl_addr[24:0]   hps_io -> responder
//   ioctl_din[7:0], ioctl_wait                 responder -> hps_io
//   pause_req / pause_ack                      responder <-> game CPU
//   ram_addr[AW-1:0], ram_rd / ram_q[7:0]      responder <-> game RAM
//   busy, done                                 responder status
// Modports    : slave  - the upload responder's view
//               master - the surrounding system's view (hps_io, CPU, RAM)
// Revision    : 1.0 - initial release
// ============================================================================
interface ioctl_ram_upload_if
  import ioctl_ram_upload_pkg::*;
#(
  parameter int AW = 10
);

  logic                ioctl_upload;
  logic                ioctl_rd;
  logic [IOCTL_AW-1:0] ioctl_addr;
  logic [7:0]          ioctl_din;
  logic                ioctl_wait;
  logic                pause_req;
  logic                pause_ack;
  logic [AW-1:0]       ram_addr;
  logic                ram_rd;
  logic [7:0]          ram_q;
  logic                busy;
  logic                done;

  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr, pause_ack, ram_q,
    output ioctl_din, ioctl_wait, pause_req, ram_addr, ram_rd, busy, done
  );

  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr, pause_ack, ram_q,
    input  ioctl_din, ioctl_wait, pause_req, ram_addr, ram_rd, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/ioctl_ram_upload.sv
`default_nettype none
// ============================================================================
// Module      : ioctl_ram_upload
// Description : Core-to-HPS upload responder. When hps_io starts an upload it
//               pauses the game CPU, then answers each ioctl_rd strobe with a
//               byte read from a spare game RAM port, holding ioctl_wait until
//               the byte is valid. Reads beyond the RAM window return FILL.
// Ports       :
//   clk        in   core system clock
//   reset_n    in   synchronous, active-low reset
//   bus        slave modport of ioctl_ram_upload_if (ioctl channel, pause
//              handshake, RAM read port, busy/done status)
// Parameters  :
//   AW       game RAM address width (window is 2^AW bytes); must match the
//            AW of the connected interface
//   RAM_LAT  RAM read latency from ram_rd to valid ram_q, 1..3 cycles
//   FILL     byte returned for out-of-window addresses
// Revision    : 1.0 - initial release
// ============================================================================
module ioctl_ram_upload
  import ioctl_ram_upload_pkg::*;
#(
  parameter int         AW      = 10,
  parameter int         RAM_LAT = 1,
  parameter logic [7:0] FILL    = UPL_FILL_DEFAULT
) (
  input  wire logic            clk,
  input  wire logic            reset_n,
  ioctl_ram_upload_if.slave    bus
);

  // State encodings kept as plain 3-bit constants for legacy tooling.
  localparam logic [2:0] S_IDLE    = UPL_IDLE;
  localparam logic [2:0] S_PAUSE   = UPL_PAUSE;
  localparam logic [2:0] S_READY   = UPL_READY;
  localparam logic [2:0] S_FETCH   = UPL_FETCH;
  localparam logic [2:0] S_RELEASE = UPL_RELEASE;

  localparam logic [1:0] LAT_LOAD = 2'(RAM_LAT);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]          r_state;
  upl_pend_t           r_pend;      // 1-deep slot for requests we cannot serve yet
  logic [IOCTL_AW-1:0] r_cur_addr;  // address of the read in flight (for retry)
  logic                r_cur_oor;   // read in flight is outside the RAM window
  logic [1:0]          r_cnt;       // cycles left until ram_q is valid
  logic [7:0]          r_din;
  logic                r_wait;
  logic                r_pause_req;
  logic                r_ram_rd;
  logic [AW-1:0]       r_ram_addr;
  logic                r_busy;
  logic                r_done;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                w_active;    // states that abort when upload drops
  logic [IOCTL_AW-1:0] w_req_addr;  // address of the request about to start
  logic                w_req_in;    // that request hits the RAM window
  logic                w_more;      // another request will be waiting after this one

  // A fresh strobe takes precedence over the slot so the last request wins.
  assign w_req_addr = bus.ioctl_rd ? bus.ioctl_addr : r_pend.addr;
  assign w_req_in   = upl_in_window(w_req_addr, AW);
  assign w_more     = bus.ioctl_rd | r_pend.valid;
  assign w_active   = (r_state == S_PAUSE) || (r_state == S_READY) ||
                      (r_state == S_FETCH);

  // --------------------------------------------------------------------------
  // FSM and datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_pend      <= '0;
      r_cur_addr  <= '0;
      r_cur_oor   <= 1'b0;
      r_cnt       <= '0;
      r_din       <= 8'h00;
      r_wait      <= 1'b0;
      r_pause_req <= 1'b0;
      r_ram_rd    <= 1'b0;
      r_ram_addr  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // Strobes are single-cycle by default.
      r_ram_rd <= 1'b0;
      r_done   <= 1'b0;

      if (w_active && !bus.ioctl_upload) begin
        // Upload ended: abandon any read, keep the last byte, free the CPU.
        r_state     <= S_RELEASE;
        r_pend      <= '0;
        r_pause_req <= 1'b0;
        r_wait      <= 1'b0;
        r_done      <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.ioctl_upload) begin
              r_state     <= S_PAUSE;
              r_pause_req <= 1'b1;
              r_wait      <= 1'b1;
              r_busy      <= 1'b1;
            end
          end

          S_PAUSE: begin
            if (bus.ioctl_rd) begin
              r_pend.valid <= 1'b1;
              r_pend.addr  <= bus.ioctl_addr;
            end
            if (bus.pause_ack) begin
              // Stay in wait if READY will immediately start a request.
              r_state <= S_READY;
              r_wait  <= w_more;
            end
          end

          S_READY: begin
            if (!bus.pause_ack) begin
              r_state <= S_PAUSE;
              r_wait  <= 1'b1;
              if (bus.ioctl_rd) begin
                r_pend.valid <= 1'b1;
                r_pend.addr  <= bus.ioctl_addr;
              end
            end else if (w_more) begin
              r_state    <= S_FETCH;
              r_wait     <= 1'b1;
              r_pend     <= '0;
              r_cur_addr <= w_req_addr;
              r_cur_oor  <= ~w_req_in;
              r_cnt      <= LAT_LOAD;
              if (w_req_in) begin
                r_ram_rd   <= 1'b1;
                r_ram_addr <= w_req_addr[AW-1:0];
              end
            end
          end

          S_FETCH: begin
            if (!bus.pause_ack) begin
              // Lost the RAM port: park the read in the slot and retry it
              // once acknowledge returns, unless a newer request is there.
              r_state <= S_PAUSE;
              r_wait  <= 1'b1;
              if (bus.ioctl_rd) begin
                r_pend.valid <= 1'b1;
                r_pend.addr  <= bus.ioctl_addr;
              end else if (!r_pend.valid) begin
                r_pend.valid <= 1'b1;
                r_pend.addr  <= r_cur_addr;
              end
            end else begin
              // A strobe here is a protocol violation; keep the newest one.
              if (bus.ioctl_rd) begin
                r_pend.valid <= 1'b1;
                r_pend.addr  <= bus.ioctl_addr;
              end
              if (r_cur_oor) begin
                r_din   <= FILL;
                r_state <= S_READY;
                r_wait  <= w_more;
              end else if (r_cnt == 2'd0) begin
                r_din   <= bus.ram_q;
                r_state <= S_READY;
                r_wait  <= w_more;
              end else begin
                r_cnt <= r_cnt - 2'd1;
              end
            end
          end

          S_RELEASE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end

          default: begin
            r_state     <= S_IDLE;
            r_pend      <= '0;
            r_pause_req <= 1'b0;
            r_wait      <= 1'b0;
            r_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all registered)
  // --------------------------------------------------------------------------
  assign bus.ioctl_din  = r_din;
  assign bus.ioctl_wait = r_wait;
  assign bus.pause_req  = r_pause_req;
  assign bus.ram_rd     = r_ram_rd;
  assign bus.ram_addr   = r_ram_addr;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ioctl_ram_upload.sv
`default_nettype none
// ============================================================================
// Module      : tb_ioctl_ram_upload
// Description : Self-checking bench for ioctl_ram_upload. One instance uses a
//               1-cycle RAM, a second uses a 3-cycle RAM for the latency and
//               mid-fetch reset cases. Expected bytes are queued when a read
//               is issued and popped when the responder drops ioctl_wait.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ioctl_ram_upload;
  import ioctl_ram_upload_pkg::*;

  logic clk;
  logic reset_n;
  logic reset_n3;

  ioctl_ram_upload_if #(.AW(10)) bus ();
  ioctl_ram_upload_if #(.AW(10)) bus3 ();

  ioctl_ram_upload #(.AW(10), .RAM_LAT(1), .FILL(8'hFF)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  ioctl_ram_upload #(.AW(10), .RAM_LAT(3), .FILL(8'hFF)) dut3 (
    .clk     (clk),
    .reset_n (reset_n3),
    .bus     (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents shared by both RAM models; data is only valid exactly
  // RAM_LAT cycles after a read strobe, otherwise the port shows 8'hEE.
  logic [7:0] mem [0:1023];
  logic [7:0] p1, p2;

  always @(posedge clk) begin
    bus.ram_q <= bus.ram_rd ? mem[bus.ram_addr] : 8'hEE;
  end

  always @(posedge clk) begin
    p1        <= bus3.ram_rd ? mem[bus3.ram_addr] : 8'hEE;
    p2        <= p1;
    bus3.ram_q <= p2;
  end

  int rdcnt = 0;
  always @(negedge clk) begin
    if (bus.ram_rd === 1'b1) rdcnt++;
  end

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] sb [$];
  logic [7:0] last_byte = 8'h00;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Called one cycle after the cycle in which the request was sampled.
  task automatic await_byte(input string tag, input int exp_lat);
    int n;
    logic [7:0] exp_b;
    n = 1;
    while (bus.ioctl_wait !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_queued"}, sb.size(), 1);
    if (sb.size() != 0) begin
      exp_b = sb.pop_front();
      chk({tag, "_din"}, bus.ioctl_din, exp_b);
      last_byte = exp_b;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    logic [7:0] e;

    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 11);
    mem[5]     = 8'hA7;
    mem[10'h20] = 8'h3C;

    reset_n  = 1'b0;
    reset_n3 = 1'b0;
    bus.ioctl_upload  = 1'b0; bus.ioctl_rd  = 1'b0; bus.ioctl_addr  = '0; bus.pause_ack  = 1'b0;
    bus3.ioctl_upload = 1'b0; bus3.ioctl_rd = 1'b0; bus3.ioctl_addr = '0; bus3.pause_ack = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_din",   bus.ioctl_din,  8'h00);
    chk("rst_wait",  bus.ioctl_wait, 1'b0);
    chk("rst_pause", bus.pause_req,  1'b0);
    chk("rst_ramrd", bus.ram_rd,     1'b0);
    chk("rst_busy",  bus.busy,       1'b0);
    chk("rst_done",  bus.done,       1'b0);
    chk("rst_raddr", bus.ram_addr,   10'd0);
    reset_n  = 1'b1;
    reset_n3 = 1'b1;
    tick();

    // Basic read: upload, acknowledge after 4 cycles, read address 5
    bus.ioctl_upload = 1'b1;
    tick();
    chk("up_pause", bus.pause_req,  1'b1);
    chk("up_wait",  bus.ioctl_wait, 1'b1);
    chk("up_busy",  bus.busy,       1'b1);
    tick(); tick(); tick();
    bus.pause_ack = 1'b1;
    tick();
    chk("ack_wait", bus.ioctl_wait, 1'b0);
    bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'h005;
    sb.push_back(mem[5]);
    tick();
    bus.ioctl_rd = 1'b0;
    chk("basic_ramrd", bus.ram_rd,     1'b1);
    chk("basic_raddr", bus.ram_addr,   10'h005);
    chk("basic_wait",  bus.ioctl_wait, 1'b1);
    await_byte("basic", 3);

    // Early request: strobe while paused, acknowledge 10 cycles later
    bus.pause_ack = 1'b0;
    tick();
    chk("repause_wait", bus.ioctl_wait, 1'b1);
    bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'h010;
    sb.push_back(mem[10'h10]);
    tick();
    bus.ioctl_rd = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("early_wait_hold", bus.ioctl_wait, 1'b1);
      if (i < 9) tick();
    end
    bus.pause_ack = 1'b1;
    tick();
    await_byte("early", 4);

    // Out of range: first address past the window, then top in-range byte
    base = rdcnt;
    bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'h400;
    sb.push_back(8'hFF);
    tick();
    bus.ioctl_rd = 1'b0;
    await_byte("oor", 2);
    chk("oor_no_ramrd", rdcnt - base, 0);
    bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'h1000000;
    sb.push_back(8'hFF);
    tick();
    bus.ioctl_rd = 1'b0;
    await_byte("oor_hi", 2);
    base = rdcnt;
    bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'h3FF;
    sb.push_back(mem[10'h3FF]);
    tick();
    bus.ioctl_rd = 1'b0;
    await_byte("top", 3);
    chk("top_ramrd_cnt", rdcnt - base, 1);

    // Abort: upload drops during FETCH
    bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'h030;
    tick();
    bus.ioctl_rd = 1'b0; bus.ioctl_upload = 1'b0; bus.pause_ack = 1'b0;
    tick();
    chk("abort_done",  bus.done,       1'b1);
    chk("abort_pause", bus.pause_req,  1'b0);
    chk("abort_wait",  bus.ioctl_wait, 1'b0);
    chk("abort_busy",  bus.busy,       1'b1);
    chk("abort_din",   bus.ioctl_din,  last_byte);
    tick();
    chk("abort_done_end", bus.done, 1'b0);
    chk("abort_idle",     bus.busy, 1'b0);
    chk("abort_din_kept", bus.ioctl_din, last_byte);

    // Next upload starts cleanly
    bus.ioctl_upload = 1'b1;
    tick();
    chk("restart_pause", bus.pause_req,  1'b1);
    chk("restart_wait",  bus.ioctl_wait, 1'b1);
    bus.pause_ack = 1'b1;
    tick();
    chk("restart_ready_wait", bus.ioctl_wait, 1'b0);

    // Acknowledge loss mid-FETCH at 0x020, then retry
    base = rdcnt;
    bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'h020;
    sb.push_back(mem[10'h20]);
    tick();
    bus.ioctl_rd = 1'b0; bus.pause_ack = 1'b0;
    tick();
    chk("ackloss_wait",  bus.ioctl_wait, 1'b1);
    chk("ackloss_pause", bus.pause_req,  1'b1);
    tick(); tick();
    chk("ackloss_wait_hold", bus.ioctl_wait, 1'b1);
    bus.pause_ack = 1'b1;
    tick();
    await_byte("retry", 4);
    chk("retry_ramrd_cnt", rdcnt - base, 2);

    // Normal end of upload
    bus.ioctl_upload = 1'b0;
    tick();
    chk("end_done",  bus.done,      1'b1);
    chk("end_pause", bus.pause_req, 1'b0);
    bus.pause_ack = 1'b0;
    tick();
    chk("end_done_end", bus.done, 1'b0);
    chk("end_idle",     bus.busy, 1'b0);

    // RAM_LAT = 3 instance: full read, then reset in the middle of a fetch
    bus3.ioctl_upload = 1'b1;
    tick();
    bus3.pause_ack = 1'b1;
    tick();
    bus3.ioctl_rd = 1'b1; bus3.ioctl_addr = 25'h007;
    sb.push_back(mem[7]);
    tick();
    bus3.ioctl_rd = 1'b0;
    n = 1;
    while (bus3.ioctl_wait !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    chk("lat3_latency", n, 5);
    chk("lat3_queued", sb.size(), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("lat3_din", bus3.ioctl_din, e);
    end
    bus3.ioctl_rd = 1'b1; bus3.ioctl_addr = 25'h008;
    tick();
    bus3.ioctl_rd = 1'b0;
    chk("lat3_ramrd", bus3.ram_rd, 1'b1);
    tick();
    reset_n3 = 1'b0;
    tick();
    chk("mrst_din",   bus3.ioctl_din,  8'h00);
    chk("mrst_wait",  bus3.ioctl_wait, 1'b0);
    chk("mrst_pause", bus3.pause_req,  1'b0);
    chk("mrst_ramrd", bus3.ram_rd,     1'b0);
    chk("mrst_busy",  bus3.busy,       1'b0);
    chk("mrst_done",  bus3.done,       1'b0);
    chk("mrst_raddr", bus3.ram_addr,   10'd0);
    bus3.ioctl_upload = 1'b0; bus3.pause_ack = 1'b0;
    reset_n3 = 1'b1;
    tick();
    chk("mrst_stay_idle", bus3.busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
